// File: rtl/key_pulse_conditioner.sv
// Synchronise, debounce and edge-detect the two tug-of-war keys.
// Optional macro DEBOUNCE_EN builds the per-key debounce FSM.

module key_pulse_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("key_pulse_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   p;

    // Idle state of the chain is "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_n};
        end
    end

    assign p = ~sync[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            acc   <= 1'b0;
            pulse <= acc;
            held  <= (state == HELD) || (state == RELEASE_WAIT);
            unique case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        cnt   <= '0;
                        acc   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // Bounce back to pressed re-enters HELD without a pulse.
                    if (p) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`else

    logic p_prev;

    // held doubles as the registered copy of p; p_prev trails it by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held   <= 1'b0;
            p_prev <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            held   <= p;
            p_prev <= held;
            pulse  <= held & ~p_prev;
        end
    end

`endif

endmodule

module key_pulse_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    output logic L,
    output logic R,
    output logic held_l,
    output logic held_r
);

    key_pulse_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .key_n(key_l_n),
        .pulse(L),
        .held (held_l)
    );

    key_pulse_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .key_n(key_r_n),
        .pulse(R),
        .held (held_r)
    );

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner.
// Expectations follow whether DEBOUNCE_EN is defined.

module tb_key_pulse_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT  = SYNC + DEB + 1;
    localparam int HLAT = SYNC + DEB + 1;
    localparam int DB   = 1;
`else
    localparam int LAT  = SYNC + 1;
    localparam int HLAT = SYNC;
    localparam int DB   = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic key_l_n = 1'b1;
    logic key_r_n = 1'b1;
    logic L, R, held_l, held_r;

    int n_run = 0;
    int n_fail = 0;

    int l_first, l_cnt, r_first, r_cnt;
    int hl_first, hl_cnt, hl_fall, hr_cnt;
    int total;

    key_pulse_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .L      (L),
        .R      (R),
        .held_l (held_l),
        .held_r (held_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run n edges; index i is the edge just passed, sampled 1 time unit later.
    task automatic run(input int n);
        l_first = -1; l_cnt = 0; r_first = -1; r_cnt = 0;
        hl_first = -1; hl_cnt = 0; hl_fall = -1; hr_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (L === 1'b1) begin
                if (l_first < 0) l_first = i;
                l_cnt++;
            end
            if (R === 1'b1) begin
                if (r_first < 0) r_first = i;
                r_cnt++;
            end
            if (held_l === 1'b1) begin
                if (hl_first < 0) hl_first = i;
                hl_cnt++;
            end else if (hl_fall < 0) begin
                hl_fall = i;
            end
            if (held_r === 1'b1) hr_cnt++;
        end
    endtask

    task automatic settle();
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        run(15);
    endtask

    initial begin
        #1;
        check("rst_L", int'(L), 0);
        check("rst_R", int'(R), 0);
        check("rst_held_l", int'(held_l), 0);
        check("rst_held_r", int'(held_r), 0);
        #21 reset = 1'b1;
        @(posedge clk);
        #1;

        // Idle keys
        run(10);
        check("idle_pulses", l_cnt + r_cnt, 0);
        check("idle_held", hl_cnt + hr_cnt, 0);

        // Long left press then release
        key_l_n = 1'b0;
        run(20);
        check("press_L_edge", l_first, LAT);
        check("press_L_count", l_cnt, 1);
        check("press_held_rise", hl_first, HLAT);
        check("press_R_quiet", r_cnt + hr_cnt, 0);
        key_l_n = 1'b1;
        run(12);
        check("release_held_fall", hl_fall, HLAT);
        check("release_L_quiet", l_cnt, 0);
        settle();

        // Short right glitch
        key_r_n = 1'b0;
        run(3);
        total = r_cnt;
        key_r_n = 1'b1;
        run(12);
        total += r_cnt;
        check("glitch3_R_count", total, DB ? 0 : 1);
        settle();

        // Accepted right press with a short release bounce
        key_r_n = 1'b0;
        run(20);
        total = r_cnt;
        key_r_n = 1'b1;
        run(3);
        total += r_cnt;
        check("bounce_held_r", hr_cnt, DB ? 3 : 2);
        key_r_n = 1'b0;
        run(15);
        total += r_cnt;
        key_r_n = 1'b1;
        run(12);
        total += r_cnt;
        check("bounce_R_count", total, DB ? 1 : 2);
        settle();

        // One-cycle left glitch
        key_l_n = 1'b0;
        run(1);
        total = l_cnt;
        key_l_n = 1'b1;
        run(12);
        total += l_cnt;
        check("glitch1_L_count", total, DB ? 0 : 1);
        settle();

        // Simultaneous presses
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        run(20);
        check("both_L_edge", l_first, LAT);
        check("both_R_edge", r_first, LAT);
        check("both_L_count", l_cnt, 1);
        check("both_R_count", r_cnt, 1);
        settle();

        // Reset while the pulse is high, key kept low across it
        key_l_n = 1'b0;
        run(LAT + 1);
        check("mid_pulse_pre", int'(L), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_L", int'(L), 0);
        check("mid_rst_held", int'(held_l), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_rst_hold_L", int'(L), 0);
        @(negedge clk);
        reset = 1'b1;
        run(20);
        check("rerelease_L_edge", l_first, LAT);
        check("rerelease_L_count", l_cnt, 1);
        check("rerelease_R_quiet", r_cnt, 0);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
